spectrum_scaler: RTL and testbench
==================================

SPECTRUM_SCALER -- requirements
Module: spectrum_scaler

Interface
REQ-001 SHALL have parameter DATA_W, default 64: magnitude sample width in bits.
REQ-002 SHALL have parameter ADDR_W, default 10: buffer depth DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter LANES, default 2, a power of two dividing DEPTH: samples handled per cycle.
REQ-004 SHALL have parameter OUT_W, default 9: width of each scaled display word.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port wr_en_i, input, 1 bit: write strobe for the input buffer.
REQ-008 SHALL have port wr_addr_i, input, ADDR_W bits: base address; lane k writes entry wr_addr_i+k.
REQ-009 SHALL have port wr_data_i, input, LANES*DATA_W bits: lane k occupies bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port start_i, input, 1 bit: one-cycle request to scale the stored frame.
REQ-011 SHALL have port mode_i, input, 1 bit: 0 = linear (MSB-aligned), 1 = log2; sampled on an accepted start_i.
REQ-012 SHALL have port rd_addr_i, input, ADDR_W bits: display read address.
REQ-013 SHALL have port rd_data_o, output, OUT_W bits: scaled word at rd_addr_i, one cycle read latency.
REQ-014 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port done_o, output, 1 bit: one-cycle pulse when the frame is scaled.
REQ-016 SHALL have port msb_o, output, clog2(DATA_W) bits: leading-one index of the frame maximum, held until the next done_o.

Function
REQ-017 SHALL implement states IDLE, SCAN, ENCODE, SCALE and DONE; start_i is accepted only in IDLE.
REQ-018 SHALL, in IDLE, write the input buffer when wr_en_i=1; wr_en_i SHALL be ignored when busy_o=1.
REQ-019 SHALL, in SCAN, read DEPTH/LANES consecutive buffer rows from address 0, with a running unsigned max across all lanes.
REQ-020 SHALL, in ENCODE (one cycle), register msb_o as the leading-one index of the max (0 when the max is 0).
REQ-021 SHALL, in SCALE, re-read all rows and write the scaled words to an internal OUT_W-wide output buffer at the same addresses.
REQ-022 SHALL, in linear mode with msb_o >= OUT_W-1, output x[msb_o -: OUT_W]; otherwise it SHALL output x zero-extended.
REQ-023 SHALL, in log2 mode, output 0 for x=0, else (leading-one index of x)+1, saturated to 2**OUT_W-1.
REQ-024 SHALL pulse done_o exactly 2*(DEPTH/LANES)+4 cycles after the accepted start_i edge, then return to IDLE.
REQ-025 SHALL ignore start_i while busy_o=1, with no queuing.
REQ-026 SHALL serve rd_addr_i in all states; reads during SCALE may return the old or the new frame.
REQ-027 SHALL wrap wr_addr_i+k modulo DEPTH.

Reset
REQ-028 SHALL, on rst, go to IDLE immediately, with busy_o=0, done_o=0 and msb_o=0, including mid-SCAN or mid-SCALE.
REQ-029 SHALL NOT clear the buffer contents on reset; rd_data_o SHALL be undefined until the first done_o.

Structure
REQ-030 SHALL take the state encoding and the mode constants (MODE_LIN, MODE_LOG) from a shared package, spectrum_pkg.
REQ-031 SHALL place the leading-one priority encoder in one sub-module, lead_one_enc, parameterised on width, used by both ENCODE and the log2 path.
REQ-032 SHALL use inferred single-clock RAMs for both buffers, one read port and one write port each, with no vendor macros.

Verification (DATA_W=64, ADDR_W=4, LANES=2, OUT_W=9)
REQ-033 All-zero frame, linear mode, start -> done_o at cycle 20, msb_o=0, all 16 rd_data_o=0.
REQ-034 Entry 5=0x3FF, all others 0x100, linear mode -> msb_o=9, entry 5 reads 0x1FF, others read 0x080.
REQ-035 Max=0x7, linear mode -> msb_o=2, rd_data_o equals the raw values (7 reads 7).
REQ-036 Entry 0=2**63, entry 1=2**55, linear mode -> msb_o=63, reads 0x100 and 0x001; log2 mode with 0x400/0/1 -> 11/0/1.
REQ-037 start_i and wr_en_i pulsed during SCAN -> ignored, done_o still at cycle 20, buffer unchanged.
REQ-038 rst asserted mid-SCALE -> busy_o=0 without waiting for clk, no done_o, and a new start completes normally.

Source files
------------

// File: rtl/spectrum_pkg.sv
// Shared definitions for the spectrum scaler.
//   state_t  : controller states (IDLE, SCAN, ENCODE, SCALE, DONE)
//   MODE_LIN : linear display scaling, aligned to the frame's leading one
//   MODE_LOG : log2 display scaling
package spectrum_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ENCODE,
        SCALE,
        DONE
    } state_t;

    localparam logic MODE_LIN = 1'b0;
    localparam logic MODE_LOG = 1'b1;

endpackage

// File: rtl/lead_one_enc.sv
// Leading-one priority encoder.
//   x   : input word
//   idx : bit index of the most significant set bit of x (0 when x is 0)
module lead_one_enc #(
    parameter int W = 64
) (
    input  logic [W-1:0]         x,
    output logic [$clog2(W)-1:0] idx
);

    localparam int IW = $clog2(W);

    // NOTE: every variable written in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (x[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/spectrum_scaler.sv
// Spectrum display scaler.
// A frame of DEPTH magnitude samples is written into an input buffer while
// idle. On start_i the frame is scanned for its maximum, the leading one of
// that maximum is encoded (msb_o), and every sample is rescaled to an
// OUT_W-bit display word held in an output buffer read through rd_addr_i.
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en_i           : write LANES samples at wr_addr_i.. (IDLE only)
//   wr_addr_i         : base entry; lane k writes entry wr_addr_i+k mod DEPTH
//   wr_data_i         : LANES samples, lane k at [k*DATA_W +: DATA_W]
//   start_i, mode_i   : start a frame; mode 0 = linear, 1 = log2
//   rd_addr_i         : display read address
//   rd_data_o         : scaled word, one cycle after rd_addr_i
//   busy_o, done_o    : not idle / one-cycle completion pulse
//   msb_o             : leading-one index of the last frame maximum
// Both buffers are banked by entry[LB-1:0] (LANES >= 2) so any LANES
// consecutive entries, wrapping or not, land in distinct banks.
module spectrum_scaler
    import spectrum_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10,
    parameter int LANES  = 2,
    parameter int OUT_W  = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [LANES*DATA_W-1:0]    wr_data_i,
    input  logic                       start_i,
    input  logic                       mode_i,
    input  logic [ADDR_W-1:0]          rd_addr_i,
    output logic [OUT_W-1:0]           rd_data_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(DATA_W)-1:0]  msb_o
);

    localparam int LB     = $clog2(LANES);
    localparam int ROW_W  = ADDR_W - LB;
    localparam int ROWS   = 2 ** ROW_W;
    localparam int MSB_W  = $clog2(DATA_W);
    localparam int OUT_MAX = (2 ** OUT_W) - 1;

    state_t                   state, state_n;
    logic [ROW_W:0]           cnt;
    logic                     row_last;
    logic                     scan_v, scale_v;
    logic [ROW_W-1:0]         row_q;
    logic                     mode_r;
    logic [DATA_W-1:0]        max_r, row_max;
    logic [MSB_W-1:0]         msb_r, max_idx;
    logic [LANES*DATA_W-1:0]  in_row;
    logic [LANES*OUT_W-1:0]   out_row;
    logic [LB-1:0]            rd_sel;
    logic                     accept, wr_ok;

    assign accept   = (state == IDLE) && start_i;
    assign wr_ok    = (state == IDLE) && wr_en_i;
    assign row_last = (cnt == (ROW_W+1)'(ROWS));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // SCAN ends once all rows are issued (the last row's data is merged on
    // the transition edge); SCALE also waits for the last write to retire.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_i) state_n = SCAN;
            SCAN:    if (row_last) state_n = ENCODE;
            ENCODE:  state_n = SCALE;
            SCALE:   if (row_last && !scale_v) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Row sequencer, read-valid pipeline, running max and encoded msb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            scan_v  <= 1'b0;
            scale_v <= 1'b0;
            row_q   <= '0;
            mode_r  <= MODE_LIN;
            max_r   <= '0;
            msb_r   <= '0;
        end else begin
            scan_v  <= (state == SCAN)  && !row_last;
            scale_v <= (state == SCALE) && !row_last;
            row_q   <= cnt[ROW_W-1:0];
            if (accept) begin
                cnt    <= '0;
                max_r  <= '0;
                mode_r <= mode_i;
            end else if (state == ENCODE) begin
                cnt    <= '0;
                msb_r  <= max_idx;
            end else if ((state == SCAN || state == SCALE) && !row_last) begin
                cnt    <= cnt + 1'b1;
            end
            if (scan_v && (row_max > max_r)) max_r <= row_max;
        end
    end

    always_comb begin
        row_max = '0;
        for (int b = 0; b < LANES; b++) begin
            if (in_row[b*DATA_W +: DATA_W] > row_max) row_max = in_row[b*DATA_W +: DATA_W];
        end
    end

    lead_one_enc #(.W(DATA_W)) u_max_enc (.x(max_r), .idx(max_idx));

    for (genvar b = 0; b < LANES; b++) begin : g_bank
        logic [DATA_W-1:0] in_mem  [ROWS];
        logic [OUT_W-1:0]  out_mem [ROWS];
        logic [LB-1:0]     lane;
        logic [ADDR_W-1:0] ent;
        logic [DATA_W-1:0] in_q;
        logic [MSB_W-1:0]  x_idx;
        logic [OUT_W-1:0]  scaled, out_q;

        // Which write lane lands in this bank, and at which entry.
        always_comb begin
            lane = LB'(b) - wr_addr_i[LB-1:0];
            ent  = wr_addr_i + ADDR_W'(lane);
        end

        // NOTE: buffer arrays carry no reset; clearing RAM would turn it
        // into flops, and the contents are defined by writes alone.
        always_ff @(posedge clk) begin
            if (wr_ok) in_mem[ent[ADDR_W-1:LB]] <= wr_data_i[int'(lane)*DATA_W +: DATA_W];
            in_q <= in_mem[cnt[ROW_W-1:0]];
        end

        lead_one_enc #(.W(DATA_W)) u_enc (.x(in_q), .idx(x_idx));

        always_comb begin
            scaled = '0;
            if (mode_r == MODE_LOG) begin
                if (in_q != '0) begin
                    if (int'(x_idx) + 1 > OUT_MAX) scaled = '1;
                    else                           scaled = OUT_W'(int'(x_idx) + 1);
                end
            end else if (int'(msb_r) >= OUT_W - 1) begin
                // Keep OUT_W bits ending at the frame's leading one.
                scaled = OUT_W'(in_q >> (int'(msb_r) - (OUT_W - 1)));
            end else begin
                scaled = OUT_W'(in_q);
            end
        end

        always_ff @(posedge clk) begin
            if (scale_v) out_mem[row_q] <= scaled;
            out_q <= out_mem[rd_addr_i[ADDR_W-1:LB]];
        end

        assign in_row[b*DATA_W +: DATA_W] = in_q;
        assign out_row[b*OUT_W +: OUT_W]  = out_q;
    end

    always_ff @(posedge clk) begin
        rd_sel <= rd_addr_i[LB-1:0];
    end

    assign rd_data_o = out_row[int'(rd_sel)*OUT_W +: OUT_W];
    assign busy_o    = (state != IDLE);
    assign done_o    = (state == DONE);
    assign msb_o     = msb_r;

endmodule

// File: tb/tb_spectrum_scaler.sv
// Self-checking bench for spectrum_scaler (DATA_W=64, ADDR_W=4, LANES=2, OUT_W=9).
module tb_spectrum_scaler;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en_i;
    logic [3:0]    wr_addr_i;
    logic [127:0]  wr_data_i;
    logic          start_i;
    logic          mode_i;
    logic [3:0]    rd_addr_i;
    logic [8:0]    rd_data_o;
    logic          busy_o;
    logic          done_o;
    logic [5:0]    msb_o;

    spectrum_scaler #(.DATA_W(64), .ADDR_W(4), .LANES(2), .OUT_W(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .start_i   (start_i),
        .mode_i    (mode_i),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .msb_o     (msb_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] ref_mem [16];

    typedef struct {
        logic        mode;
        logic [63:0] fill;
        int          sp_addr;
        logic [63:0] sp_val;
        int          exp_msb;
        int          exp_sp;
        int          exp_other;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Position of the highest set bit, by repeated halving; -1 for zero.
    function automatic int lead(input logic [63:0] x);
        int n = -1;
        while (x != 0) begin
            x = x >> 1;
            n++;
        end
        return n;
    endfunction

    function automatic int frame_msb();
        logic [63:0] mx = 0;
        for (int i = 0; i < 16; i++) if (ref_mem[i] > mx) mx = ref_mem[i];
        return (mx == 0) ? 0 : lead(mx);
    endfunction

    function automatic logic [8:0] exp_word(input logic [63:0] x, input int m, input logic mode);
        int v;
        if (mode) begin
            if (x == 0) return 9'd0;
            v = lead(x) + 1;
            if (v > 511) v = 511;
            return 9'(v);
        end
        if (m >= 8) return 9'(x >> (m - 8));
        return 9'(x);
    endfunction

    task automatic write_lanes(input int a, input logic [63:0] d0, input logic [63:0] d1);
        @(negedge clk);
        wr_en_i   = 1'b1;
        wr_addr_i = 4'(a);
        wr_data_i = {d1, d0};
        @(posedge clk);
        #1;
        wr_en_i = 1'b0;
        ref_mem[a % 16]       = d0;
        ref_mem[(a + 1) % 16] = d1;
    endtask

    // Starts a frame, optionally pokes start_i/wr_en_i mid-SCAN, and
    // measures the cycles from the accepting edge to done_o.
    task automatic run_frame(input logic mode, input bit inject);
        int  n = 0;
        bit  seen = 0;
        @(negedge clk);
        start_i = 1'b1;
        mode_i  = mode;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("busy_after_start", 64'(busy_o), 64'd1);
        while (!seen && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (inject && n == 3) begin
                start_i   = 1'b1;
                wr_en_i   = 1'b1;
                wr_addr_i = 4'd0;
                wr_data_i = '1;
            end else if (inject && n == 4) begin
                start_i = 1'b0;
                wr_en_i = 1'b0;
            end
            if (done_o) seen = 1;
        end
        check("done_latency", 64'(n), 64'd20);
        @(posedge clk);
        #1;
        check("idle_after_done", {62'd0, busy_o, done_o}, 64'd0);
    endtask

    task automatic read_one(input int a, input logic [8:0] exp, input string tag);
        @(negedge clk);
        rd_addr_i = 4'(a);
        @(posedge clk);
        #1;
        check($sformatf("%s_rd%0d", tag, a), 64'(rd_data_o), 64'(exp));
    endtask

    task automatic check_model(input logic mode, input string tag);
        int m = frame_msb();
        check({tag, "_msb"}, 64'(msb_o), 64'(m));
        for (int a = 0; a < 16; a++) read_one(a, exp_word(ref_mem[a], m, mode), tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 64'h0,   3,  64'h0,   0,  0,     0};
        tbl[1] = '{1'b0, 64'h100, 5,  64'h3FF, 9,  'h1FF, 'h080};
        tbl[2] = '{1'b0, 64'h3,   7,  64'h7,   2,  7,     3};
        tbl[3] = '{1'b1, 64'h1,   12, 64'h400, 10, 11,    1};

        rst = 1'b1; wr_en_i = 0; wr_addr_i = 0; wr_data_i = '0;
        start_i = 0; mode_i = 0; rd_addr_i = 0;
        #12;
        check("reset_state", {57'd0, busy_o, done_o, msb_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table: uniform fill plus one distinguished entry.
        for (int t = 0; t < 4; t++) begin
            for (int a = 0; a < 16; a += 2) write_lanes(a, tbl[t].fill, tbl[t].fill);
            write_lanes(tbl[t].sp_addr, tbl[t].sp_val, tbl[t].fill);
            run_frame(tbl[t].mode, 0);
            check($sformatf("tbl%0d_msb", t), 64'(msb_o), 64'(tbl[t].exp_msb));
            for (int a = 0; a < 16; a++)
                read_one(a, 9'((a == tbl[t].sp_addr) ? tbl[t].exp_sp : tbl[t].exp_other),
                         $sformatf("tbl%0d", t));
        end

        // Extreme magnitudes in linear mode, then a small log2 frame.
        for (int a = 0; a < 16; a += 2) write_lanes(a, 64'd0, 64'd0);
        write_lanes(0, 64'h8000_0000_0000_0000, 64'h0080_0000_0000_0000);
        run_frame(1'b0, 0);
        check("top_msb", 64'(msb_o), 64'd63);
        read_one(0, 9'h100, "top");
        read_one(1, 9'h001, "top");
        read_one(2, 9'h000, "top");
        write_lanes(0, 64'h400, 64'h0);
        write_lanes(2, 64'h1, 64'h0);
        run_frame(1'b1, 0);
        read_one(0, 9'd11, "log");
        read_one(1, 9'd0, "log");
        read_one(2, 9'd1, "log");

        // Write at the last entry wraps lane 1 to entry 0.
        write_lanes(15, 64'h1234, 64'h5);
        run_frame(1'b0, 0);
        check_model(1'b0, "wrap");

        // start_i and wr_en_i during SCAN must have no effect.
        run_frame(1'b0, 1);
        check_model(1'b0, "ignore");

        // Randomized frames against the reference model.
        for (int f = 0; f < 6; f++) begin
            logic r_mode = 1'($urandom_range(0, 1));
            for (int w = 0; w < 10; w++) begin
                logic [63:0] d0 = {$urandom, $urandom} >> $urandom_range(0, 63);
                logic [63:0] d1 = {$urandom, $urandom} >> $urandom_range(0, 63);
                if ($urandom_range(0, 7) == 0) d0 = 64'd0;
                write_lanes(int'($urandom_range(0, 15)), d0, d1);
            end
            run_frame(r_mode, 0);
            check_model(r_mode, $sformatf("rnd%0d", f));
        end

        // Reset in the middle of SCALE.
        begin
            int dones = 0;
            @(negedge clk);
            start_i = 1'b1;
            mode_i  = 1'b0;
            @(posedge clk);
            #1;
            start_i = 1'b0;
            repeat (13) @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            check("abort_async_state", {57'd0, busy_o, done_o, msb_o}, 64'd0);
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            repeat (30) begin
                @(posedge clk);
                #1;
                if (done_o || busy_o) dones++;
            end
            check("abort_stays_idle", 64'(dones), 64'd0);
            run_frame(1'b0, 0);
            check_model(1'b0, "after_abort");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
